// File: rtl/adder_pkg.sv
// Shared widths and types for the registered 33-bit adder used by the
// Booth shift-add multiplier datapath.
package adder_pkg;

    localparam int ADD_W      = 33;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = (ADD_W - 1) / SLICE_W;

    typedef logic [ADD_W-1:0] word33_t;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// Single-bit full adder, the building block of the ripple-carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder_cell

// File: rtl/adder33bit_reg.sv
// Registered 33-bit two's-complement ripple-carry adder with carry-out and
// signed-overflow flags; one-cycle latency, one operation per cycle.
module adder33bit_reg
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    word33_t sum_s;
    logic    c32_in_s;
    logic    c32_out_s;

    // Each cell owns its carry-in net so the ripple chain is a series of
    // distinct signals rather than a self-referencing vector.
    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        for (genvar j = 0; j < SLICE_W; j++) begin : g_bit
            logic ci_s;
            logic co_s;

            if (j > 0) begin : g_ci_chain
                assign ci_s = g_bit[j-1].co_s;
            end else if (k > 0) begin : g_ci_slice
                assign ci_s = g_slice[k-1].g_bit[SLICE_W-1].co_s;
            end else begin : g_ci_first
                assign ci_s = cin;
            end

            full_adder_cell u_fa (
                .a  (a[k*SLICE_W+j]),
                .b  (b[k*SLICE_W+j]),
                .ci (ci_s),
                .s  (sum_s[k*SLICE_W+j]),
                .co (co_s)
            );
        end
    end

    assign c32_in_s = g_slice[NUM_SLICES-1].g_bit[SLICE_W-1].co_s;

    full_adder_cell u_fa_msb (
        .a  (a[ADD_W-1]),
        .b  (b[ADD_W-1]),
        .ci (c32_in_s),
        .s  (sum_s[ADD_W-1]),
        .co (c32_out_s)
    );

    word33_t s_d, s_q;
    logic    cout_d, cout_q;
    logic    ovf_d, ovf_q;
    logic    valid_d, valid_q;

    // Capture a new result on valid, otherwise hold the last one.
    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (in_valid) begin
            s_d     = sum_s;
            cout_d  = c32_out_s;
            ovf_d   = c32_in_s ^ c32_out_s;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output and valid registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= {ADD_W{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule : adder33bit_reg

// File: tb/tb_adder33bit_reg.sv
// Self-checking bench for adder33bit_reg: directed corner cases plus random
// traffic against an arithmetic reference model.
module tb_adder33bit_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [32:0] a;
    logic [32:0] b;
    logic        cin;
    logic [32:0] s;
    logic        cout;
    logic        ovf;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Last captured result {out_valid, cout, ovf, s}, used for hold checks.
    logic [35:0] last_res;

    adder33bit_reg #(.WIDTH(33)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum gives s/cout; signed sum out of range gives ovf.
    function automatic logic [35:0] model(input logic [32:0] ma, input logic [32:0] mb,
                                          input logic mc);
        logic [33:0] usum;
        longint      ssum;
        logic        m_ovf;
        usum  = {1'b0, ma} + {1'b0, mb} + {33'd0, mc};
        ssum  = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        m_ovf = (ssum > 64'sd4294967295) || (ssum < -64'sd4294967296);
        return {1'b1, usum[33], m_ovf, usum[32:0]};
    endfunction

    function automatic logic [32:0] rnd33();
        logic [32:0] r;
        r = {$urandom_range(1, 0) == 1, $urandom()};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [32:0] da, input logic [32:0] db,
                         input logic dc);
        @(negedge clk);
        in_valid = v;
        a        = da;
        b        = db;
        cin      = dc;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rnd33(), rnd33(), 1'($urandom_range(1, 0)));
            @(posedge clk);
            #1;
            got = {out_valid, cout, ovf, s};
            n_checks++;
            if (got !== 36'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h expected %h", i, got, 36'd0);
            end
        end
        drive(1'b0, rnd33(), rnd33(), 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            got = {out_valid, cout, ovf, s};
            n_checks++;
            if (got !== 36'd0) begin
                n_fail++;
                $display("FAIL reset_release cyc%0d: got %h expected %h", i, got, 36'd0);
            end
        end
    endtask

    // Directed capture table: {a, b, cin, expected {valid,cout,ovf,s}}.
    task automatic test_directed();
        logic [32:0] ta [6];
        logic [32:0] tb [6];
        logic        tc [6];
        logic [35:0] te [6];
        logic [35:0] got;
        ta[0] = 33'h0_0000_0005; tb[0] = 33'h0_0000_0003; tc[0] = 1'b0; te[0] = {1'b1, 1'b0, 1'b0, 33'h0_0000_0008};
        ta[1] = 33'h0_0000_0005; tb[1] = 33'h1_FFFF_FFFC; tc[1] = 1'b1; te[1] = {1'b1, 1'b1, 1'b0, 33'h0_0000_0002};
        ta[2] = 33'h0_FFFF_FFFF; tb[2] = 33'h0_0000_0001; tc[2] = 1'b0; te[2] = {1'b1, 1'b0, 1'b1, 33'h1_0000_0000};
        ta[3] = 33'h1_0000_0000; tb[3] = 33'h1_0000_0000; tc[3] = 1'b0; te[3] = {1'b1, 1'b1, 1'b1, 33'h0_0000_0000};
        ta[4] = 33'h1_FFFF_FFFF; tb[4] = 33'h0_0000_0000; tc[4] = 1'b1; te[4] = {1'b1, 1'b1, 1'b0, 33'h0_0000_0000};
        ta[5] = 33'h0_AAAA_5555; tb[5] = 33'h1_5555_AAAA; tc[5] = 1'b1; te[5] = {1'b1, 1'b1, 1'b0, 33'h0_0000_0000};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i]);
            @(posedge clk);
            #1;
            got = {out_valid, cout, ovf, s};
            n_checks++;
            if (got !== te[i]) begin
                n_fail++;
                $display("FAIL directed%0d: got %h expected %h", i, got, te[i]);
            end
            last_res = te[i];
        end
    endtask

    task automatic test_hold();
        logic [35:0] got;
        logic [35:0] exp_v;
        drive(1'b1, 33'h1_FFFF_FFFF, 33'h0, 1'b1);
        @(posedge clk);
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 33'h0};
        got = {out_valid, cout, ovf, s};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL ripple_full: got %h expected %h", got, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rnd33(), rnd33(), 1'($urandom_range(1, 0)));
            @(posedge clk);
            #1;
            exp_v = {1'b0, 1'b1, 1'b0, 33'h0};
            got = {out_valid, cout, ovf, s};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL hold%0d: got %h expected %h", i, got, exp_v);
            end
        end
        last_res = exp_v;
    endtask

    task automatic test_back_to_back();
        logic [32:0] ta [3];
        logic [32:0] tb [3];
        logic [35:0] got;
        logic [35:0] exp_v;
        ta[0] = 33'd1;           tb[0] = 33'd1;
        ta[1] = 33'd2;           tb[1] = 33'd2;
        ta[2] = 33'h0_7FFF_FFFF; tb[2] = 33'd1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ta[i], tb[i], 1'b0);
            @(posedge clk);
            #1;
            exp_v = model(ta[i], tb[i], 1'b0);
            got = {out_valid, cout, ovf, s};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL b2b%0d: got %h expected %h", i, got, exp_v);
            end
        end
        drive(1'b0, 33'd0, 33'd0, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [35:0] got;
        logic [35:0] exp_v;
        drive(1'b1, 33'd1, 33'd1, 1'b0);
        drive(1'b1, 33'd2, 33'd2, 1'b0);
        @(posedge clk);
        #1;
        exp_v = model(33'd2, 33'd2, 1'b0);
        got = {out_valid, cout, ovf, s};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_second: got %h expected %h", got, exp_v);
        end
        drive(1'b1, 33'h0_7FFF_FFFF, 33'd1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        got = {out_valid, cout, ovf, s};
        n_checks++;
        if (got !== 36'd0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got %h expected %h", got, 36'd0);
        end
        @(posedge clk);
        #1;
        got = {out_valid, cout, ovf, s};
        n_checks++;
        if (got !== 36'd0) begin
            n_fail++;
            $display("FAIL midrst_during: got %h expected %h", got, 36'd0);
        end
        drive(1'b0, 33'h0_7FFF_FFFF, 33'd1, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = {out_valid, cout, ovf, s};
        n_checks++;
        if (got !== 36'd0) begin
            n_fail++;
            $display("FAIL midrst_discard: got %h expected %h", got, 36'd0);
        end
        last_res = 36'd0;
    endtask

    task automatic test_random();
        logic [35:0] got;
        logic [35:0] exp_v;
        logic [32:0] ra;
        logic [32:0] rb;
        logic        rc;
        logic        rv;
        for (int i = 0; i < 200; i++) begin
            rv = ($urandom_range(3, 0) != 0);
            ra = rnd33();
            rb = rnd33();
            rc = 1'($urandom_range(1, 0));
            if ($urandom_range(7, 0) == 0) ra = 33'h0_FFFF_FFFF;
            if ($urandom_range(7, 0) == 0) rb = 33'h1_0000_0000;
            drive(rv, ra, rb, rc);
            @(posedge clk);
            #1;
            if (rv) begin
                exp_v = model(ra, rb, rc);
            end else begin
                exp_v = {1'b0, last_res[34:0]};
            end
            last_res = exp_v;
            got = {out_valid, cout, ovf, s};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL random%0d: a=%h b=%h cin=%b v=%b got %h expected %h",
                         i, ra, rb, rc, rv, got, exp_v);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 33'd0;
        b        = 33'd0;
        cin      = 1'b0;
        last_res = 36'd0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder33bit_reg
